// File: rtl/ieee488_device_hs.sv
// Device-side IEEE-488 acceptor/source handshake engine.
// Converts open-collector bus traffic into a one-entry receive buffer and a valid/ready transmit port.
module ieee488_device_hs #(
   parameter int SETTLE_CE   = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ce,
   input  logic       listen,
   input  logic       talk,
   input  logic [7:0] ieee488_data_i,
   input  logic       ieee488_atn_i,
   input  logic       ieee488_dav_i,
   input  logic       ieee488_eoi_i,
   input  logic       ieee488_nrfd_i,
   input  logic       ieee488_ndac_i,
   input  logic       ieee488_ifc_i,
   output logic [7:0] ieee488_data_o,
   output logic       ieee488_dav_o,
   output logic       ieee488_eoi_o,
   output logic       ieee488_nrfd_o,
   output logic       ieee488_ndac_o,
   output logic [7:0] rx_data,
   output logic       rx_eoi,
   output logic       rx_atn,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_eoi,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_err
);

   localparam int CW  = $clog2(SETTLE_CE + 2);
   localparam int NIN = 14;

   typedef enum logic [1:0] {AH_AIDS = 2'd0, AH_ANRS = 2'd1, AH_ACRS = 2'd2, AH_AWNS = 2'd3} ah_state_t;
   typedef enum logic [1:0] {SH_SIDS = 2'd0, SH_SGNS = 2'd1, SH_SDYS = 2'd2, SH_STRS = 2'd3} sh_state_t;

   logic [NIN-1:0] sync_r [SYNC_STAGES];
   logic [NIN-1:0] bus_s;
   logic [7:0]     data_s;
   logic           atn_s, dav_s, eoi_s, nrfd_s, ndac_s, ifc_s;
   logic           acc_active_s, src_en_s;

   ah_state_t      ah_state_r;
   sh_state_t      sh_state_r;
   logic           nrfd_r, ndac_r, dav_r, eoi_o_r;
   logic [7:0]     data_o_r, rx_data_r;
   logic           rx_eoi_r, rx_atn_r, rx_valid_r, tx_ready_r, tx_err_r;
   logic [CW-1:0]  settle_r;

   // Bus input synchroniser chain; idle (released) level out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '1;
      end else begin
         sync_r[0] <= {ieee488_ifc_i, ieee488_ndac_i, ieee488_nrfd_i, ieee488_eoi_i,
                       ieee488_dav_i, ieee488_atn_i, ieee488_data_i};
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      end
   end

   assign bus_s        = sync_r[SYNC_STAGES-1];
   assign data_s       = bus_s[7:0];
   assign atn_s        = bus_s[8];
   assign dav_s        = bus_s[9];
   assign eoi_s        = bus_s[10];
   assign nrfd_s       = bus_s[11];
   assign ndac_s       = bus_s[12];
   assign ifc_s        = bus_s[13];
   assign acc_active_s = listen | ~atn_s;
   assign src_en_s     = talk & atn_s;

   // Acceptor handshake and receive buffer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ah_state_r <= AH_AIDS;
         nrfd_r     <= 1'b1;
         ndac_r     <= 1'b1;
         rx_data_r  <= 8'h00;
         rx_eoi_r   <= 1'b0;
         rx_atn_r   <= 1'b0;
         rx_valid_r <= 1'b0;
      end else begin
         if (rx_valid_r && rx_ready) rx_valid_r <= 1'b0;
         if (!ifc_s) begin
            ah_state_r <= AH_AIDS;
            nrfd_r     <= 1'b1;
            ndac_r     <= 1'b1;
         end else begin
            case (ah_state_r)
               AH_AIDS: begin
                  if (acc_active_s) begin
                     ah_state_r <= AH_ANRS;
                     nrfd_r     <= 1'b0;
                     ndac_r     <= 1'b0;
                  end else begin
                     nrfd_r <= 1'b1;
                     ndac_r <= 1'b1;
                  end
               end
               AH_ANRS: begin
                  if (!acc_active_s) begin
                     ah_state_r <= AH_AIDS;
                     nrfd_r     <= 1'b1;
                     ndac_r     <= 1'b1;
                  end else if (!rx_valid_r && dav_s) begin
                     ah_state_r <= AH_ACRS;
                     nrfd_r     <= 1'b1;
                     ndac_r     <= 1'b0;
                  end else begin
                     nrfd_r <= 1'b0;
                     ndac_r <= 1'b0;
                  end
               end
               AH_ACRS: begin
                  if (!acc_active_s) begin
                     ah_state_r <= AH_AIDS;
                     nrfd_r     <= 1'b1;
                     ndac_r     <= 1'b1;
                  end else if (!dav_s) begin
                     // Bus data and flags are negative logic
                     rx_data_r  <= ~data_s;
                     rx_eoi_r   <= ~eoi_s;
                     rx_atn_r   <= ~atn_s;
                     rx_valid_r <= 1'b1;
                     ah_state_r <= AH_AWNS;
                     nrfd_r     <= 1'b0;
                     ndac_r     <= 1'b1;
                  end else begin
                     nrfd_r <= 1'b1;
                     ndac_r <= 1'b0;
                  end
               end
               AH_AWNS: begin
                  if (dav_s) begin
                     ah_state_r <= AH_ANRS;
                     nrfd_r     <= 1'b0;
                     ndac_r     <= 1'b0;
                  end else begin
                     nrfd_r <= 1'b0;
                     ndac_r <= 1'b1;
                  end
               end
               default: begin
                  ah_state_r <= AH_AIDS;
                  nrfd_r     <= 1'b1;
                  ndac_r     <= 1'b1;
               end
            endcase
         end
      end
   end

   // Source handshake with data/EOI settle time before DAV
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_state_r <= SH_SIDS;
         dav_r      <= 1'b1;
         eoi_o_r    <= 1'b1;
         data_o_r   <= 8'hFF;
         tx_ready_r <= 1'b0;
         tx_err_r   <= 1'b0;
         settle_r   <= '0;
      end else begin
         tx_err_r <= 1'b0;
         if (!ifc_s || !src_en_s) begin
            sh_state_r <= SH_SIDS;
            dav_r      <= 1'b1;
            eoi_o_r    <= 1'b1;
            data_o_r   <= 8'hFF;
            tx_ready_r <= 1'b0;
            settle_r   <= '0;
         end else begin
            case (sh_state_r)
               SH_SIDS: begin
                  sh_state_r <= SH_SGNS;
                  tx_ready_r <= 1'b1;
               end
               SH_SGNS: begin
                  if (tx_valid && tx_ready_r) begin
                     data_o_r   <= ~tx_data;
                     eoi_o_r    <= ~tx_eoi;
                     settle_r   <= '0;
                     tx_ready_r <= 1'b0;
                     sh_state_r <= SH_SDYS;
                  end else begin
                     tx_ready_r <= 1'b1;
                  end
               end
               SH_SDYS: begin
                  if (settle_r != CW'(SETTLE_CE)) begin
                     if (ce) settle_r <= settle_r + CW'(1);
                     else    settle_r <= settle_r;
                  end else if (nrfd_s && !ndac_s) begin
                     dav_r      <= 1'b0;
                     sh_state_r <= SH_STRS;
                  end else if (nrfd_s && ndac_s) begin
                     // Nobody is holding NDAC: no listener, drop the byte
                     tx_err_r   <= 1'b1;
                     data_o_r   <= 8'hFF;
                     eoi_o_r    <= 1'b1;
                     tx_ready_r <= 1'b1;
                     sh_state_r <= SH_SGNS;
                  end else begin
                     settle_r <= settle_r;
                  end
               end
               SH_STRS: begin
                  if (ndac_s) begin
                     dav_r      <= 1'b1;
                     data_o_r   <= 8'hFF;
                     eoi_o_r    <= 1'b1;
                     tx_ready_r <= 1'b1;
                     sh_state_r <= SH_SGNS;
                  end else begin
                     dav_r <= 1'b0;
                  end
               end
               default: begin
                  sh_state_r <= SH_SIDS;
                  dav_r      <= 1'b1;
                  eoi_o_r    <= 1'b1;
                  data_o_r   <= 8'hFF;
                  tx_ready_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ieee488_data_o = data_o_r;
   assign ieee488_dav_o  = dav_r;
   assign ieee488_eoi_o  = eoi_o_r;
   assign ieee488_nrfd_o = nrfd_r;
   assign ieee488_ndac_o = ndac_r;
   assign rx_data        = rx_data_r;
   assign rx_eoi         = rx_eoi_r;
   assign rx_atn         = rx_atn_r;
   assign rx_valid       = rx_valid_r;
   assign tx_ready       = tx_ready_r;
   assign tx_err         = tx_err_r;

endmodule

// File: doc/ieee488_device_hs.md
Name: ieee488_device_hs

Overview:
- Device-side (peripheral) IEEE-488 byte handshake engine: Acceptor Handshake (AH) and Source Handshake (SH), the opposite end of the PET controller's GPIB port.
- Used by the emulated disk drive and other bus devices. It turns bus-level DAV/NRFD/NDAC/EOI/ATN/IFC traffic into a valid/ready byte stream with flags, and back.
- Open-collector bus: all bus signals are bus-level, 1 = released/high, 0 = asserted. Data lines are negative logic.
- Outputs are wired-AND externally.

Parameters:
- SETTLE_CE, 2: ce ticks the data/EOI lines must be stable before DAV is asserted (T1).
- SYNC_STAGES, 2: synchroniser flops on every bus input.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  timing enable (1 MHz); used only for the settle counter
- listen  in  1  device addressed as listener
- talk  in  1  device addressed as talker
- ieee488_data_i  in  8  bus data lines (bus level)
- ieee488_atn_i, ieee488_dav_i, ieee488_eoi_i, ieee488_nrfd_i, ieee488_ndac_i, ieee488_ifc_i  in  1 each  bus control lines
- ieee488_data_o  out  8  driven data lines
- ieee488_dav_o, ieee488_eoi_o, ieee488_nrfd_o, ieee488_ndac_o  out  1 each  driven control lines
- rx_data  out  8  received byte, logic polarity (~bus)
- rx_eoi  out  1  EOI was asserted with the byte
- rx_atn  out  1  byte is a command (ATN asserted)
- rx_valid  out  1  receive buffer full
- rx_ready  in  1  consumer takes the byte
- tx_data  in  8  byte to send, logic polarity
- tx_eoi  in  1  send with EOI
- tx_valid  in  1  byte offered
- tx_ready  out  1  source accepts the byte this cycle
- tx_err  out  1  one-cycle pulse: no listener present, byte dropped

Behaviour:
- Reset (async):
  - All bus outputs released (1); ieee488_data_o = 8'hFF.
  - rx_valid = 0, rx_eoi = 0, rx_atn = 0, rx_data = 0, tx_ready = 0, tx_err = 0.
  - Both FSMs enter idle; the settle counter clears.
- Input synchronisation: all bus inputs pass through SYNC_STAGES flops. FSM decisions use the synchronised values only.
- IFC asserted (synchronised 0): both FSMs go to idle next cycle and release all lines. The receive buffer keeps its contents.
- Receive buffer: one entry.
  - rx_valid & rx_ready clears rx_valid that cycle.
  - A new byte can only be written when the buffer is empty (guaranteed by NRFD).
- Acceptor is active when (listen | ATN asserted). ATN always forces acceptance of command bytes.
  - AIDS: NRFD and NDAC released. If active → ANRS.
  - ANRS: NRFD = 0, NDAC = 0. If !active → AIDS. If rx_valid = 0 and DAV released → ACRS.
  - ACRS: NRFD released, NDAC = 0. If !active → AIDS. If DAV asserted → capture into the buffer and go to AWNS:
    - rx_data = ~data_i
    - rx_eoi = ~eoi_i
    - rx_atn = ~atn_i
    - rx_valid <= 1
  - AWNS: NRFD = 0, NDAC released. Stays here until DAV released; an ATN change does not abort the handshake. Then → ANRS.
  - Latency: DAV asserted at the pins to rx_valid = 1 is SYNC_STAGES+1 clk.
- Source is enabled when talk & ATN released.
  - SIDS: all source lines released, tx_ready = 0. If enabled → SGNS.
  - SGNS: tx_ready = 1. On tx_valid & tx_ready → latch the byte and go to SDYS:
    - data_o = ~tx_data
    - eoi_o = ~tx_eoi
    - settle counter = 0
  - SDYS: data and EOI driven. The counter increments on ce until it reaches SETTLE_CE. Then:
    - NRFD released & NDAC asserted → STRS.
    - NRFD and NDAC both released → pulse tx_err, release data/EOI, → SGNS.
    - Otherwise wait.
  - STRS: DAV = 0. When NDAC is released → release DAV, data and EOI, → SGNS.
  - ATN asserted or talk = 0 in any source state: release DAV, data and EOI on the next clk, → SIDS. A byte in flight is lost and tx_err is not pulsed.
- Simultaneous talk and listen: both FSMs run independently. The host must not request both; no arbitration is performed.

Test Plan:
- Reset mid-byte: assert reset_n = 0 during STRS → all outputs 1 and data_o = FF immediately; after release, FSMs are idle.
- Listen receive: listen = 1, rx_ready = 0; controller drives data_i = 8'hBE (logic 0x41), eoi_i = 0, DAV = 0 → rx_data = 0x41, rx_eoi = 1, rx_atn = 0, rx_valid = 1, NDAC released. After DAV is released, NRFD stays 0 until a rx_ready pulse, then NRFD is released.
- ATN command with listen = 0: ATN = 0, DAV = 0 on bus data 8'hD7 (logic 0x28) → rx_data = 0x28, rx_atn = 1.
- Talk send: talk = 1, tx_data = 0x55, tx_eoi = 1; listener holds NDAC = 0 and releases NRFD → data_o = 8'hAA and eoi_o = 0. DAV falls exactly SETTLE_CE ce ticks after latch (plus sync). Listener releases NDAC → DAV, data and EOI released within SYNC_STAGES+1 clk.
- No listener: talk = 1, NRFD = NDAC = 1 → one tx_err pulse, DAV never asserted, data released, tx_ready = 1 again.
- ATN abort: ATN asserted while in STRS → DAV/data/EOI released next clk, tx_ready = 0 (SIDS), no tx_err.
